sent_frame_tx: RTL and testbench
================================

// Module: sent_frame_tx
// PURPOSE
//  SENT transmit sequencer and pulse encoder, downstream of sent_crc. Accepts a frame of
//  status plus data nibbles, requests the CRC nibble from sent_crc, then drives the SENT line.
//  Symbol order: sync, status, data, CRC, optional pause.
//  Each symbol is a fixed low pulse followed by a high period.
// PARAMETERS
//  DIV_W       16  width of tick_div (clock cycles per SENT tick, minus 1)
//  LOW_TICKS    5  low-pulse length of every symbol, in ticks
//  CRC_TMO     31  clock cycles to wait for sent_crc_ack before aborting
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, asynchronous, active-high
//  tick_div       in   DIV_W  clocks per tick minus 1; sampled at frame accept
//  pause_en       in   1      append pause pulse; sampled at frame accept
//  pause_ticks    in   12     pause symbol length in ticks; values below 12 are treated as 12
//  frame_valid    in   1      frame offered
//  frame_ready    out  1      frame accepted when valid && ready
//  frame_status   in   4      status/comm nibble
//  frame_len      in   3      data nibble count, 1..7
//  frame_data     in   28     data nibbles, first nibble in [27:24]
//  sent_crc_req   out  1      one-cycle CRC request
//  sent_frame_len out  3      length to sent_crc, held from accept
//  sent_frame_data out 28     data to sent_crc, held from accept
//  sent_crc_ack   in   1      CRC valid strobe
//  sent_crc       in   4      CRC nibble, sampled when ack=1
//  sent_out       out  1      SENT line; idle high
//  busy           out  1      high from accept until frame end
//  frame_done     out  1      one-cycle pulse at the end of the last symbol
//  frame_err      out  1      one-cycle pulse on reject or CRC timeout
// BEHAVIOUR
//  Reset values: sent_out=1, frame_ready=0, busy=0, sent_crc_req=0, frame_done=0,
//   frame_err=0, state=IDLE.
//  frame_ready=1 only in IDLE and not in reset. Reset mid-frame forces sent_out=1
//   immediately and abandons the frame.
//  Accept (cycle 0): latch status, len, data, tick_div, pause_en and pause_ticks; busy=1.
//  If frame_len==0: frame_err pulses at cycle 1, the block returns to IDLE, and sent_out is not disturbed.
//  States: IDLE -> CRC_REQ -> CRC_WAIT -> SYNC -> STATUS -> DATA -> CRC -> [PAUSE] -> IDLE.
//  CRC_REQ: sent_crc_req=1 for exactly cycle 1.
//  CRC_WAIT: counts clocks. On sent_crc_ack, latch sent_crc and go to SYNC.
//   If CRC_TMO clocks pass with no ack: frame_err pulse, return to IDLE, sent_out stays 1.
//  Tick generator: a down-counter reloads tick_div and emits a 1-clock tick at 0.
//   It restarts on entry to SYNC, so the first tick comes tick_div+1 clocks later.
//  Symbol lengths (ticks): SYNC=56, nibble v=12+v (12..27), PAUSE=max(pause_ticks,12).
//  Symbol timing: sent_out goes low on the tick that starts the symbol. It stays low LOW_TICKS ticks,
//   then high for the remaining ticks. The next symbol starts on the tick after the last tick.
//  DATA: emit frame_len nibbles, MSB nibble first; the shift register moves by 4 per nibble.
//  frame_done pulses on the final tick of CRC (no pause) or of PAUSE. busy clears the same cycle.
//   frame_ready rises the next cycle.
//  Frame length in ticks: 56+(12+status)+sum(12+d)+(12+crc)[+pause].
//  Back-to-back: if a new valid is present in IDLE, accept it at once. Its sync starts
//   after the CRC handshake, so the line is high for at least a few clocks between frames.
//  Inputs that change while busy are ignored. frame_valid during busy is not accepted.
//  tick_div=0 gives one tick per clock and is legal.
// STRUCTURE
//  Package sent_pkg: state encoding, SYNC_TICKS=56, NIBBLE_BASE=12, PAUSE_MIN=12.
//  Submodule sent_pulse_gen: inputs tick, start, sym_ticks[11:0], low_ticks.
//   Outputs line level and sym_done on the final tick. Holds the symbol tick counter.
//  The top level holds the FSM, the tick divider, frame latches, the nibble shifter
//   and the CRC handshake.
// TESTING
//  1 tick_div=0, status=0, len=6, data=0x0123450, CRC ack after 3 cycles with 0xA:
//    line low/high periods 5/51, 5/7, 5/7, 5/8, 5/9, 5/10, 5/11, 5/12, 5/17 ticks; one frame_done.
//  2 Same frame with pause_en=1, pause_ticks=5 -> pause symbol is 12 ticks (5 low/7 high).
//    frame_done pulses at the end of the pause.
//  3 sent_crc_ack never asserted -> frame_err pulses at 31 cycles after the crc_req cycle.
//    sent_out stays 1 throughout; frame_ready returns to 1.
//  4 frame_len=0 -> frame_err at cycle 1, no sent_crc_req, sent_out stays 1.
//  5 rst asserted midway through the DATA nibbles -> sent_out=1 and busy=0 the same cycle.
//    After release, a new frame starts cleanly with sync.
//  6 tick_div=3 with frame_valid held high: two consecutive frames.
//    Each sync is 224 clocks long; frame_ready is high for 1 cycle between the frames.

Source files
------------

// File: rtl/sent_pkg.sv
// Shared definitions for the SENT transmit path: FSM encoding, symbol lengths and
// the nibble-to-tick helper.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CRC_REQ  = 3'd1,
        ST_CRC_WAIT = 3'd2,
        ST_SYNC     = 3'd3,
        ST_STATUS   = 3'd4,
        ST_DATA     = 3'd5,
        ST_CRC      = 3'd6,
        ST_PAUSE    = 3'd7
    } sent_state_e;

    typedef logic [11:0] sym_ticks_t;

    localparam sym_ticks_t SYNC_TICKS  = 12'd56;
    localparam sym_ticks_t NIBBLE_BASE = 12'd12;
    localparam sym_ticks_t PAUSE_MIN   = 12'd12;

    function automatic sym_ticks_t nibble_ticks(input logic [3:0] v);
        return NIBBLE_BASE + {8'd0, v};
    endfunction

endpackage

// File: rtl/sent_pulse_gen.sv
// One SENT symbol: low for low_ticks ticks from the start tick, then high until the
// symbol's final tick, which is flagged on sym_done.
module sent_pulse_gen
    import sent_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  sym_ticks_t sym_ticks,
    input  sym_ticks_t low_ticks,
    output logic       line,
    output logic       sym_done
);

    sym_ticks_t cnt_r;
    logic       line_r;

    // cnt_r holds the index of the next tick within the symbol; the start tick is index 0
    assign sym_done = tick && !start && (cnt_r == (sym_ticks - 12'd1));
    assign line     = line_r;

    // Symbol tick counter and line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 12'd0;
            line_r <= 1'b1;
        end else if (tick) begin
            if (start) begin
                cnt_r  <= 12'd1;
                line_r <= 1'b0;
            end else begin
                if (cnt_r == low_ticks) begin
                    line_r <= 1'b1;
                end
                cnt_r <= cnt_r + 12'd1;
            end
        end
    end

endmodule

// File: rtl/sent_frame_tx.sv
// SENT transmit sequencer: accepts a frame, fetches its CRC from sent_crc, then sends
// sync, status, data nibbles, CRC and an optional pause on the SENT line.
module sent_frame_tx
    import sent_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int LOW_TICKS = 5,
    parameter int CRC_TMO   = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] tick_div,
    input  logic             pause_en,
    input  logic [11:0]      pause_ticks,
    input  logic             frame_valid,
    output logic             frame_ready,
    input  logic [3:0]       frame_status,
    input  logic [2:0]       frame_len,
    input  logic [27:0]      frame_data,
    output logic             sent_crc_req,
    output logic [2:0]       sent_frame_len,
    output logic [27:0]      sent_frame_data,
    input  logic             sent_crc_ack,
    input  logic [3:0]       sent_crc,
    output logic             sent_out,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int TMO_W = $clog2(CRC_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CRC_TMO - 1);

    sent_state_e      state_r;
    logic [3:0]       status_r;
    logic [2:0]       len_r;
    logic [27:0]      data_r;
    logic [27:0]      shift_r;
    logic [2:0]       nib_cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] tick_cnt_r;
    logic             pause_en_r;
    sym_ticks_t       pause_r;
    logic [3:0]       crc_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             start_r;
    logic             frame_ready_r;
    logic             busy_r;
    logic             req_r;
    logic             done_r;
    logic             err_r;

    logic             sym_state_s;
    logic             tick_s;
    sym_ticks_t       sym_ticks_s;
    logic             sym_done_s;

    // Tick generation is only live while a symbol state is active
    always_comb begin
        sym_state_s = 1'b0;
        if ((state_r == ST_SYNC) || (state_r == ST_STATUS) || (state_r == ST_DATA) ||
            (state_r == ST_CRC) || (state_r == ST_PAUSE)) begin
            sym_state_s = 1'b1;
        end else begin
            sym_state_s = 1'b0;
        end
        tick_s = sym_state_s && (tick_cnt_r == {DIV_W{1'b0}});
    end

    // Length of the symbol currently on the line
    always_comb begin
        sym_ticks_s = SYNC_TICKS;
        case (state_r)
            ST_SYNC:   sym_ticks_s = SYNC_TICKS;
            ST_STATUS: sym_ticks_s = nibble_ticks(status_r);
            ST_DATA:   sym_ticks_s = nibble_ticks(shift_r[27:24]);
            ST_CRC:    sym_ticks_s = nibble_ticks(crc_r);
            ST_PAUSE:  sym_ticks_s = pause_r;
            default:   sym_ticks_s = SYNC_TICKS;
        endcase
    end

    sent_pulse_gen u_pulse (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick_s),
        .start     (start_r),
        .sym_ticks (sym_ticks_s),
        .low_ticks (12'(LOW_TICKS)),
        .line      (sent_out),
        .sym_done  (sym_done_s)
    );

    // Frame sequencer, tick divider, frame latches, nibble shifter and CRC handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            status_r      <= 4'd0;
            len_r         <= 3'd0;
            data_r        <= 28'd0;
            shift_r       <= 28'd0;
            nib_cnt_r     <= 3'd0;
            div_r         <= {DIV_W{1'b0}};
            tick_cnt_r    <= {DIV_W{1'b0}};
            pause_en_r    <= 1'b0;
            pause_r       <= PAUSE_MIN;
            crc_r         <= 4'd0;
            tmo_cnt_r     <= {TMO_W{1'b0}};
            start_r       <= 1'b0;
            frame_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            req_r         <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            req_r  <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (sym_state_s) begin
                tick_cnt_r <= tick_s ? div_r : (tick_cnt_r - DIV_W'(1));
            end
            if (tick_s && start_r) begin
                start_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (frame_valid && frame_ready_r) begin
                        status_r      <= frame_status;
                        len_r         <= frame_len;
                        data_r        <= frame_data;
                        shift_r       <= frame_data;
                        nib_cnt_r     <= frame_len;
                        div_r         <= tick_div;
                        pause_en_r    <= pause_en;
                        pause_r       <= (pause_ticks < PAUSE_MIN) ? PAUSE_MIN : pause_ticks;
                        tmo_cnt_r     <= {TMO_W{1'b0}};
                        frame_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        if (frame_len == 3'd0) begin
                            err_r <= 1'b1;
                        end else begin
                            req_r   <= 1'b1;
                            state_r <= ST_CRC_REQ;
                        end
                    end else begin
                        frame_ready_r <= 1'b1;
                        busy_r        <= 1'b0;
                    end
                end
                ST_CRC_REQ: begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    state_r   <= ST_CRC_WAIT;
                end
                ST_CRC_WAIT: begin
                    if (sent_crc_ack) begin
                        crc_r      <= sent_crc;
                        start_r    <= 1'b1;
                        tick_cnt_r <= div_r;
                        state_r    <= ST_SYNC;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_SYNC: begin
                    if (sym_done_s) begin
                        start_r <= 1'b1;
                        state_r <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (sym_done_s) begin
                        start_r <= 1'b1;
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sym_done_s) begin
                        start_r   <= 1'b1;
                        shift_r   <= {shift_r[23:0], 4'd0};
                        nib_cnt_r <= nib_cnt_r - 3'd1;
                        if (nib_cnt_r == 3'd1) begin
                            state_r <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (sym_done_s) begin
                        if (pause_en_r) begin
                            start_r <= 1'b1;
                            state_r <= ST_PAUSE;
                        end else begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (sym_done_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_ready     = frame_ready_r;
    assign busy            = busy_r;
    assign sent_crc_req    = req_r;
    assign sent_frame_len  = len_r;
    assign sent_frame_data = data_r;
    assign frame_done      = done_r;
    assign frame_err       = err_r;

endmodule

// File: tb/tb_sent_frame_tx.sv
// Directed bench for sent_frame_tx: a CRC responder answers requests, a negedge
// monitor timestamps line edges and strobes, and frames are checked symbol by symbol.
module tb_sent_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tick_div;
    logic        pause_en;
    logic [11:0] pause_ticks;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  frame_status;
    logic [2:0]  frame_len;
    logic [27:0] frame_data;
    logic        sent_crc_req;
    logic [2:0]  sent_frame_len;
    logic [27:0] sent_frame_data;
    logic        sent_crc_ack;
    logic [3:0]  sent_crc;
    logic        sent_out;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    sent_frame_tx dut (
        .clk             (clk),
        .rst             (rst),
        .tick_div        (tick_div),
        .pause_en        (pause_en),
        .pause_ticks     (pause_ticks),
        .frame_valid     (frame_valid),
        .frame_ready     (frame_ready),
        .frame_status    (frame_status),
        .frame_len       (frame_len),
        .frame_data      (frame_data),
        .sent_crc_req    (sent_crc_req),
        .sent_frame_len  (sent_frame_len),
        .sent_frame_data (sent_frame_data),
        .sent_crc_ack    (sent_crc_ack),
        .sent_crc        (sent_crc),
        .sent_out        (sent_out),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int falls[$];
    int rises[$];
    int dones[$];
    int errs[$];
    int reqs[$];
    logic prev_line = 1'b1;
    bit   ack_en    = 1'b1;
    int   ack_dly   = 3;
    int   ack_cnt   = 0;
    int   exp_hi[10];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamp line edges and strobes with the posedge count
    always @(negedge clk) begin
        if (rst) begin
            prev_line = 1'b1;
        end else begin
            if (sent_out !== prev_line) begin
                if (sent_out === 1'b0) falls.push_back(cyc);
                else rises.push_back(cyc);
                prev_line = sent_out;
            end
            if (frame_done)   dones.push_back(cyc);
            if (frame_err)    errs.push_back(cyc);
            if (sent_crc_req) reqs.push_back(cyc);
        end
    end

    // sent_crc stand-in: one-cycle ack ack_dly cycles after each request
    always @(negedge clk) begin
        if (rst) begin
            ack_cnt      = 0;
            sent_crc_ack = 1'b0;
        end else begin
            sent_crc_ack = 1'b0;
            if (sent_crc_req && ack_en) begin
                ack_cnt = ack_dly;
            end else if (ack_cnt != 0) begin
                ack_cnt = ack_cnt - 1;
                if (ack_cnt == 0) sent_crc_ack = 1'b1;
            end
        end
    end

    task automatic clear_mon();
        falls.delete(); rises.delete(); dones.delete(); errs.delete(); reqs.delete();
    endtask

    task automatic send_frame(input logic [3:0] st, input logic [2:0] len, input logic [27:0] data,
                              input logic [15:0] td, input logic pen, input logic [11:0] pt);
        @(negedge clk);
        frame_status = st; frame_len = len; frame_data = data;
        tick_div = td; pause_en = pen; pause_ticks = pt; frame_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check_eq("accept", busy, 1'b1);
        frame_valid = 1'b0;
        // Garbage while busy must not reach the frame in flight
        frame_status = ~st; frame_len = 3'd7; frame_data = ~data;
        tick_div = 16'd9; pause_en = ~pen; pause_ticks = 12'd40;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && frame_ready) break;
        end
        check_eq(tag, frame_ready, 1'b1);
    endtask

    // Line periods in ticks (tick_div=0); the last symbol ends one tick after frame_done's tick
    task automatic check_frame(input string tag, input int nsym);
        check_eq({tag, "_nsym"}, falls.size(), nsym);
        check_eq({tag, "_ndone"}, dones.size(), 1);
        if (falls.size() == nsym && rises.size() == nsym && dones.size() == 1) begin
            for (int i = 0; i < nsym; i++) begin
                check_eq($sformatf("%s_low%0d", tag, i), rises[i] - falls[i], 5);
                if (i < nsym - 1)
                    check_eq($sformatf("%s_high%0d", tag, i), falls[i+1] - rises[i], exp_hi[i]);
                else
                    check_eq($sformatf("%s_high%0d", tag, i), dones[0] + 1 - rises[i], exp_hi[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rdy;
        rst = 1'b1; frame_valid = 1'b0; frame_status = 4'd0; frame_len = 3'd0;
        frame_data = 28'd0; tick_div = 16'd0; pause_en = 1'b0; pause_ticks = 12'd0;
        sent_crc = 4'hA;
        repeat (3) @(negedge clk);
        check_eq("rst_sent_out", sent_out, 1'b1);
        check_eq("rst_ready", frame_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_req", sent_crc_req, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        check_eq("rst_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("ready_after_rst", frame_ready, 1'b1);

        // 1: basic frame, tick per clock
        clear_mon();
        send_frame(4'd0, 3'd6, 28'h0123450, 16'd0, 1'b0, 12'd5);
        wait_idle("t1_idle", 2000);
        exp_hi = '{51, 7, 7, 8, 9, 10, 11, 12, 17, 0};
        check_frame("t1", 9);
        check_eq("t1_nreq", reqs.size(), 1);
        check_eq("t1_flen", sent_frame_len, 6);
        check_eq("t1_fdata", sent_frame_data, 28'h0123450);

        // 2: same frame with short pause clamped to 12 ticks
        clear_mon();
        send_frame(4'd0, 3'd6, 28'h0123450, 16'd0, 1'b1, 12'd5);
        wait_idle("t2_idle", 2000);
        exp_hi = '{51, 7, 7, 8, 9, 10, 11, 12, 17, 7};
        check_frame("t2", 10);

        // 3: CRC never acknowledged
        clear_mon();
        ack_en = 1'b0;
        send_frame(4'd3, 3'd2, 28'h5500000, 16'd0, 1'b0, 12'd12);
        wait_idle("t3_idle", 200);
        check_eq("t3_nerr", errs.size(), 1);
        check_eq("t3_nreq", reqs.size(), 1);
        if (errs.size() == 1 && reqs.size() == 1)
            check_eq("t3_err_delay", errs[0] - reqs[0], 31);
        check_eq("t3_nfall", falls.size(), 0);
        check_eq("t3_ndone", dones.size(), 0);
        ack_en = 1'b1;

        // 4: zero-length frame is rejected
        clear_mon();
        @(negedge clk);
        frame_len = 3'd0; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        check_eq("t4_err", frame_err, 1'b1);
        check_eq("t4_busy", busy, 1'b1);
        check_eq("t4_req", sent_crc_req, 1'b0);
        @(negedge clk);
        check_eq("t4_err_clr", frame_err, 1'b0);
        check_eq("t4_busy_clr", busy, 1'b0);
        check_eq("t4_ready", frame_ready, 1'b1);
        repeat (40) @(negedge clk);
        check_eq("t4_nreq", reqs.size(), 0);
        check_eq("t4_nfall", falls.size(), 0);
        check_eq("t4_nerr", errs.size(), 1);

        // 5: reset during the data nibbles, then a clean frame
        clear_mon();
        send_frame(4'd0, 3'd6, 28'h0123450, 16'd0, 1'b0, 12'd5);
        for (int i = 0; i < 500 && falls.size() < 3; i++) @(negedge clk);
        check_eq("t5_in_data_low", sent_out, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_line", sent_out, 1'b1);
        check_eq("t5_rst_busy", busy, 1'b0);
        check_eq("t5_rst_ready", frame_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        send_frame(4'd0, 3'd6, 28'h0123450, 16'd0, 1'b0, 12'd5);
        wait_idle("t5_idle", 2000);
        exp_hi = '{51, 7, 7, 8, 9, 10, 11, 12, 17, 0};
        check_frame("t5", 9);

        // 6: back-to-back frames with tick_div=3
        clear_mon();
        @(negedge clk);
        frame_status = 4'd0; frame_len = 3'd1; frame_data = 28'h7000000;
        tick_div = 16'd3; pause_en = 1'b0; pause_ticks = 12'd12; frame_valid = 1'b1;
        rdy = 0;
        for (int i = 0; i < 3000 && reqs.size() < 2; i++) begin
            @(negedge clk);
            if (dones.size() == 1 && frame_ready) rdy++;
        end
        frame_valid = 1'b0;
        wait_idle("t6_idle", 3000);
        check_eq("t6_ndone", dones.size(), 2);
        check_eq("t6_nfall", falls.size(), 8);
        check_eq("t6_ready_gap", rdy, 1);
        if (falls.size() == 8 && dones.size() == 2) begin
            check_eq("t6_sync1", falls[1] - falls[0], 224);
            check_eq("t6_sync2", falls[5] - falls[4], 224);
            check_eq("t6_idle_gap", (falls[4] - dones[0]) >= 4, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
